// File: rtl/niveles_carga_hist.sv
// ---------------------------------------------------------------------------
// niveles_carga_hist
//
// Battery charge-level classifier with hysteresis and a hold filter.
// The N_BAT charge samples are summed into a registered total, which is
// classified against 25 / 50 / 75 % of MAX_CARGA. The level is committed
// only after HOLD consecutive valid samples agree on the same new level.
// Each threshold is shifted by HYST away from the current level, so a
// total sitting on a threshold cannot make the outputs chatter.
//
// Ports
//   clk             system clock, rising edge
//   rst_n           synchronous reset, active-low
//   muestra_valida  carga_baterias is valid this cycle
//   carga_baterias  packed charges, battery i at [i*W +: W]
//   carga_total     registered full-width sum of the last valid sample
//   nivel           committed level: 0 critico, 1 regular, 2 aceptable,
//                   3 optimo
//   optimo, aceptable, regular, critico
//                   registered one-hot decode of nivel
//   cambio          single-cycle pulse on the cycle nivel changes
// ---------------------------------------------------------------------------
module niveles_carga_hist #(
    parameter int N_BAT     = 2,
    parameter int W         = 4,
    parameter int MAX_CARGA = 30,
    parameter int HOLD      = 4,
    parameter int HYST      = 1,
    // Sum width: N_BAT values of W bits never exceed W + clog2(N_BAT) bits.
    localparam int SW       = W + $clog2(N_BAT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 muestra_valida,
    input  logic [N_BAT*W-1:0]   carga_baterias,
    output logic [SW-1:0]        carga_total,
    output logic [1:0]           nivel,
    output logic                 optimo,
    output logic                 aceptable,
    output logic                 regular,
    output logic                 critico,
    output logic                 cambio
);

    // Thresholds in plain 32-bit integer arithmetic (truncating division).
    localparam int T3 = MAX_CARGA * 75 / 100;
    localparam int T2 = MAX_CARGA * 50 / 100;
    localparam int T1 = MAX_CARGA * 25 / 100;

    // Hold counter only has to reach HOLD.
    localparam int CW = $clog2(HOLD + 1);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    if (N_BAT < 1) begin : g_err_nbat
        $error("niveles_carga_hist: N_BAT must be >= 1");
    end
    if (HOLD < 1) begin : g_err_hold
        $error("niveles_carga_hist: HOLD must be >= 1");
    end
    if (HYST < 0) begin : g_err_hyst_neg
        $error("niveles_carga_hist: HYST must be >= 0");
    end
    // Every hysteresis band must stay inside its own level, otherwise the
    // shifted thresholds could overlap and a level would become unreachable.
    if ((T1 <= HYST) || ((T2 - T1) <= 2 * HYST) || ((T3 - T2) <= 2 * HYST))
    begin : g_err_hyst_band
        $error("niveles_carga_hist: HYST too large for MAX_CARGA thresholds");
    end
    if (MAX_CARGA >= (1 << SW)) begin : g_err_max
        $error("niveles_carga_hist: MAX_CARGA does not fit in SW bits");
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [SW-1:0] carga_total_reg;
    logic [SW-1:0] carga_total_next;
    logic          v1_reg;
    logic [1:0]    nivel_reg;
    logic [1:0]    nivel_next;
    logic [1:0]    pend_reg;
    logic [1:0]    pend_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          cambio_reg;
    logic          cambio_next;
    logic [3:0]    onehot_reg;   // {optimo, aceptable, regular, critico}
    logic [3:0]    onehot_next;

    // -----------------------------------------------------------------------
    // Stage 1: channel extraction and summation
    // -----------------------------------------------------------------------
    logic [SW-1:0] canal [N_BAT];
    logic [SW-1:0] suma;

    for (genvar gi = 0; gi < N_BAT; gi++) begin : g_canal
        assign canal[gi] = SW'(carga_baterias[gi*W +: W]);
    end

    always_comb begin
        suma = '0;
        for (int i = 0; i < N_BAT; i++) begin
            suma = suma + canal[i];
        end
    end

    // The total is only refreshed by valid samples and otherwise holds.
    always_comb begin
        carga_total_next = carga_total_reg;
        if (muestra_valida) begin
            carga_total_next = suma;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: hysteresis comparison
    // -----------------------------------------------------------------------
    // A threshold above the current level must be exceeded by HYST to climb;
    // a threshold at or below it must be undershot by HYST to fall.
    logic [31:0] total32;
    logic [2:0]  supera;
    logic [1:0]  cand;

    assign total32 = 32'(carga_total_reg);

    for (genvar gi = 1; gi <= 3; gi++) begin : g_umbral
        localparam int T    = (gi == 3) ? T3 : ((gi == 2) ? T2 : T1);
        localparam int SUBE = T + HYST;
        localparam int BAJA = T - HYST;
        assign supera[gi-1] = (int'(nivel_reg) < gi) ? (total32 >= 32'(SUBE))
                                                     : (total32 >= 32'(BAJA));
    end

    // Candidate level = number of effective thresholds reached.
    assign cand = 2'({1'b0, supera[0]} + {1'b0, supera[1]} + {1'b0, supera[2]});

    // -----------------------------------------------------------------------
    // Hold filter and commit
    // -----------------------------------------------------------------------
    logic [CW-1:0] cuenta;

    always_comb begin
        nivel_next  = nivel_reg;
        pend_next   = pend_reg;
        cnt_next    = cnt_reg;
        cambio_next = 1'b0;
        cuenta      = '0;
        if (v1_reg) begin
            if (cand == nivel_reg) begin
                // Any sample agreeing with the committed level restarts the hold.
                cnt_next  = '0;
                pend_next = nivel_reg;
            end else begin
                if (cand == pend_reg) begin
                    cuenta = cnt_reg + CW'(1);
                end else begin
                    // A different candidate starts its own run from one.
                    cuenta    = CW'(1);
                    pend_next = cand;
                end
                if (int'(cuenta) >= HOLD) begin
                    // Commit directly, even across several levels.
                    nivel_next  = cand;
                    pend_next   = cand;
                    cnt_next    = '0;
                    cambio_next = 1'b1;
                end else begin
                    cnt_next = cuenta;
                end
            end
        end
    end

    // One-hot outputs are registered alongside nivel so they switch together.
    always_comb begin
        onehot_next = 4'b0000;
        onehot_next[nivel_next] = 1'b1;
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carga_total_reg <= '0;
            v1_reg          <= 1'b0;
            nivel_reg       <= 2'd0;
            pend_reg        <= 2'd0;
            cnt_reg         <= '0;
            cambio_reg      <= 1'b0;
            onehot_reg      <= 4'b0001;
        end else begin
            carga_total_reg <= carga_total_next;
            v1_reg          <= muestra_valida;
            nivel_reg       <= nivel_next;
            pend_reg        <= pend_next;
            cnt_reg         <= cnt_next;
            cambio_reg      <= cambio_next;
            onehot_reg      <= onehot_next;
        end
    end

    assign carga_total = carga_total_reg;
    assign nivel       = nivel_reg;
    assign cambio      = cambio_reg;
    assign optimo      = onehot_reg[3];
    assign aceptable   = onehot_reg[2];
    assign regular     = onehot_reg[1];
    assign critico     = onehot_reg[0];

endmodule

// File: tb/tb_niveles_carga_hist.sv
`timescale 1ns/1ps
// Testbench for niveles_carga_hist.
// Instance A uses default parameters and is driven from a per-cycle vector
// table; each row's expected outputs go into a scoreboard queue when the row
// is driven and are popped and compared just after the clock edge.
// Instance B (N_BAT=4, W=4, MAX_CARGA=60, HOLD=1) gets a hand-written sequence.
module tb_niveles_carga_hist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A (defaults) ----------------
    logic        rst_n_a = 1'b0;
    logic        valid_a = 1'b0;
    logic [7:0]  carga_a = '0;
    logic [4:0]  total_a;
    logic [1:0]  nivel_a;
    logic        opt_a, acep_a, reg_a, crit_a, cambio_a;

    niveles_carga_hist dut_a (
        .clk            (clk),
        .rst_n          (rst_n_a),
        .muestra_valida (valid_a),
        .carga_baterias (carga_a),
        .carga_total    (total_a),
        .nivel          (nivel_a),
        .optimo         (opt_a),
        .aceptable      (acep_a),
        .regular        (reg_a),
        .critico        (crit_a),
        .cambio         (cambio_a)
    );

    // ---------------- instance B (wide) ----------------
    logic        rst_n_b = 1'b0;
    logic        valid_b = 1'b0;
    logic [15:0] carga_b = '0;
    logic [5:0]  total_b;
    logic [1:0]  nivel_b;
    logic        opt_b, acep_b, reg_b, crit_b, cambio_b;

    niveles_carga_hist #(
        .N_BAT(4), .W(4), .MAX_CARGA(60), .HOLD(1), .HYST(1)
    ) dut_b (
        .clk            (clk),
        .rst_n          (rst_n_b),
        .muestra_valida (valid_b),
        .carga_baterias (carga_b),
        .carga_total    (total_b),
        .nivel          (nivel_b),
        .optimo         (opt_b),
        .aceptable      (acep_b),
        .regular        (reg_b),
        .critico        (crit_b),
        .cambio         (cambio_b)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // {optimo, aceptable, regular, critico} for a level
    function automatic logic [3:0] onehot(input logic [1:0] n);
        return {n == 2'd3, n == 2'd2, n == 2'd1, n == 2'd0};
    endfunction

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] total;
        logic [1:0] nivel;
        logic       cambio;
    } vec_t;

    typedef struct {
        int         row;
        logic [4:0] total;
        logic [1:0] nivel;
        logic       cambio;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic add(input logic r, input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [4:0] t, input logic [1:0] n, input logic c);
        vec_t x;
        x.rst_n = r; x.valid = v; x.a = a; x.b = b;
        x.total = t; x.nivel = n; x.cambio = c;
        vecs.push_back(x);
    endtask

    // Watchdog: the whole run is a few hundred cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;

        // ---- table: each row is one cycle, expectations seen after its edge ----
        // reset
        add(0, 0, 0, 0,  0, 0, 0);
        add(0, 0, 0, 0,  0, 0, 0);
        // rise 0 -> 3 after 4 samples of 24
        for (int i = 0; i < 4; i++) add(1, 1, 12, 12, 24, 0, 0);
        add(1, 0, 0, 0, 24, 3, 1);
        add(1, 0, 0, 0, 24, 3, 0);
        // hysteresis: 21 holds optimo, 20 drops to aceptable after 4
        for (int i = 0; i < 6; i++) add(1, 1, 10, 11, 21, 3, 0);
        for (int i = 0; i < 4; i++) add(1, 1, 10, 10, 20, 3, 0);
        add(1, 0, 0, 0, 20, 2, 1);
        add(1, 0, 0, 0, 20, 2, 0);
        // interrupted hold: 5,5,5,16,5,5,5 never commits
        for (int i = 0; i < 3; i++) add(1, 1, 2, 3, 5, 2, 0);
        add(1, 1, 8, 8, 16, 2, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 2, 3, 5, 2, 0);
        add(1, 0, 0, 0, 5, 2, 0);
        add(1, 0, 0, 0, 5, 2, 0);
        // gapped samples of 24 still commit after the 4th
        for (int i = 0; i < 4; i++) begin
            add(1, 1, 12, 12, 24, 2, 0);
            if (i < 3) add(1, 0, 0, 0, 24, 2, 0);
            else       add(1, 0, 0, 0, 24, 3, 1);
        end
        add(1, 0, 0, 0, 24, 3, 0);
        // reset, 3 gapped samples, reset (with valid high), 3 more do not commit
        add(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            add(1, 1, 12, 12, 24, 0, 0);
            add(1, 0, 0, 0, 24, 0, 0);
        end
        add(0, 1, 12, 12, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            add(1, 1, 12, 12, 24, 0, 0);
            if (i < 3) add(1, 0, 0, 0, 24, 0, 0);
            else       add(1, 0, 0, 0, 24, 3, 1);
        end
        add(1, 0, 0, 0, 24, 3, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n_a = vecs[i].rst_n;
            valid_a = vecs[i].valid;
            carga_a = {vecs[i].b, vecs[i].a};
            e.row = i; e.total = vecs[i].total; e.nivel = vecs[i].nivel; e.cambio = vecs[i].cambio;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 0, 1);
            end else begin
                e = sb.pop_front();
                chk($sformatf("row%0d carga_total", e.row), 32'(total_a), 32'(e.total));
                chk($sformatf("row%0d nivel", e.row), 32'(nivel_a), 32'(e.nivel));
                chk($sformatf("row%0d cambio", e.row), 32'(cambio_a), 32'(e.cambio));
                chk($sformatf("row%0d onehot", e.row), 32'({opt_a, acep_a, reg_a, crit_a}),
                    32'(onehot(e.nivel)));
            end
        end
        chk("scoreboard_drained", 32'(sb.size()), 0);

        // ---- instance B: wide sum, HOLD = 1 ----
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); rst_n_b = 1'b0; valid_b = 1'b0;
            @(posedge clk); #1;
            chk("B reset total", 32'(total_b), 0);
            chk("B reset onehot", 32'({opt_b, acep_b, reg_b, crit_b}), 32'(4'b0001));
            chk("B reset cambio", 32'(cambio_b), 0);
        end
        @(negedge clk); rst_n_b = 1'b1; valid_b = 1'b1; carga_b = {4{4'd15}};
        @(posedge clk); #1;
        chk("B total 60", 32'(total_b), 60);
        chk("B nivel before", 32'(nivel_b), 0);
        @(negedge clk); valid_b = 1'b0;
        @(posedge clk); #1;
        chk("B nivel optimo", 32'(nivel_b), 3);
        chk("B onehot optimo", 32'({opt_b, acep_b, reg_b, crit_b}), 32'(4'b1000));
        chk("B cambio up", 32'(cambio_b), 1);
        @(negedge clk); valid_b = 1'b1; carga_b = {4'd0, 4'd15, 4'd0, 4'd15};
        @(posedge clk); #1;
        chk("B total 30", 32'(total_b), 30);
        chk("B cambio quiet", 32'(cambio_b), 0);
        @(negedge clk); valid_b = 1'b0;
        @(posedge clk); #1;
        chk("B nivel aceptable", 32'(nivel_b), 2);
        chk("B cambio down", 32'(cambio_b), 1);
        @(negedge clk); valid_b = 1'b1; carga_b = '0;
        @(posedge clk); #1;
        chk("B total 0", 32'(total_b), 0);
        @(negedge clk); valid_b = 1'b0;
        @(posedge clk); #1;
        chk("B nivel critico", 32'(nivel_b), 0);
        chk("B onehot critico", 32'({opt_b, acep_b, reg_b, crit_b}), 32'(4'b0001));
        chk("B cambio to zero", 32'(cambio_b), 1);
        @(posedge clk); #1;
        chk("B cambio settles", 32'(cambio_b), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
